// File: rtl/vga_text_pkg.sv
// vga_text_pkg: geometry defaults, control codes and state/cursor-op enums for the text console.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package vga_text_pkg;

   localparam int COLS_DEF      = 80;
   localparam int ROWS_DEF      = 30;
   localparam int WORDS_PER_ROW = COLS_DEF / 2;
   localparam int SCREEN_WORDS  = ROWS_DEF * WORDS_PER_ROW;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_DEL   = 8'h7F;

   typedef enum logic [2:0] {
      INIT_CLR,
      IDLE,
      CHAR_WR,
      SCR_RD,
      SCR_WR,
      ROW_CLR,
      FF_CLR
   } state_e;

   typedef enum logic [2:0] {
      CUR_NONE,
      CUR_ADV,
      CUR_LF,
      CUR_CR,
      CUR_BS,
      CUR_HOME
   } cur_op_e;

   // Bytes that produce a visible cell: 0x20..0x7E and the whole upper half.
   function automatic logic is_printable(input logic [7:0] b);
      return (b >= CH_SPACE) && (b != CH_DEL);
   endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// vga_text_console_if: byte stream into the console, one byte plus attribute per handshake.
// Latency: none (wires only).
// Backpressure: source holds in_valid/in_data/in_attr until in_ready is seen high.
interface vga_text_console_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] in_attr;
   logic       in_ready;

   modport master (output in_valid, output in_data, output in_attr, input in_ready);
   modport slave  (input in_valid, input in_data, input in_attr, output in_ready);

endinterface

// File: rtl/text_cursor.sv
// text_cursor: row/col registers with advance+wrap, newline, carriage return, backspace and home.
// Latency: requested op takes effect on the next clock edge.
// Backpressure: none; overflow flags tell the FSM when a row step must become a scroll.
module text_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  cur_op_e    op,
   output logic [4:0] row,
   output logic [6:0] col,
   output logic       adv_ovf,
   output logic       lf_ovf
);

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);

   logic [4:0] row_q, row_d;
   logic [6:0] col_q, col_d;

   assign row     = row_q;
   assign col     = col_q;
   // On the last row the row never moves; the FSM scrolls the picture instead.
   assign lf_ovf  = (row_q == LAST_ROW);
   assign adv_ovf = (col_q == LAST_COL) && (row_q == LAST_ROW);

   // Next cursor position for the requested operation.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      case (op)
         CUR_ADV: begin
            if (col_q == LAST_COL) begin
               col_d = 7'd0;
               if (row_q != LAST_ROW) row_d = row_q + 5'd1;
            end else begin
               col_d = col_q + 7'd1;
            end
         end
         CUR_LF: begin
            col_d = 7'd0;
            if (row_q != LAST_ROW) row_d = row_q + 5'd1;
         end
         CUR_CR: col_d = 7'd0;
         CUR_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
         CUR_HOME: begin
            row_d = 5'd0;
            col_d = 7'd0;
         end
         default: ;
      endcase
   end

   // Cursor registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= 5'd0;
         col_q <= 7'd0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/vga_text_console.sv
// vga_text_console: byte stream to {attr,char} cells with LF/CR/BS/FF, line wrap and hardware scroll.
// Latency: printable byte written the cycle after accept; scroll 2360 cycles; full clears 1200 cycles.
// Backpressure: in_ready only in IDLE; a held in_valid waits out clears and scrolls.
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter int         COLS         = COLS_DEF,
   parameter int         ROWS         = ROWS_DEF,
   parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
   input  logic               clk,
   input  logic               reset,
   vga_text_console_if.slave  in_if,
   output logic               fb_en,
   output logic [3:0]         fb_we,
   output logic [10:0]        fb_addr,
   output logic [31:0]        fb_wdata,
   input  logic [31:0]        fb_rdata,
   output logic [4:0]         cur_row,
   output logic [6:0]         cur_col,
   output logic               busy
);

   localparam logic [10:0] WPR        = 11'(COLS / 2);
   localparam logic [10:0] LAST_WORD  = 11'(ROWS * (COLS / 2) - 1);
   localparam logic [10:0] LAST_ROW_W = 11'((ROWS - 1) * (COLS / 2));

   state_e      state_q, state_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  attr_q, attr_d;
   logic [7:0]  char_q, char_d;
   logic        wr_q, wr_d;      // CHAR_WR must write a cell
   logic        adv_q, adv_d;    // CHAR_WR must advance the cursor

   cur_op_e     cur_op;
   logic        adv_ovf, lf_ovf;
   logic [10:0] cell_addr;

   logic        rdy_c, busy_c, en_c;
   logic [3:0]  we_c;
   logic [10:0] addr_c;
   logic [31:0] wdata_c;

   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk     (clk),
      .reset   (reset),
      .op      (cur_op),
      .row     (cur_row),
      .col     (cur_col),
      .adv_ovf (adv_ovf),
      .lf_ovf  (lf_ovf)
   );

   // Two cells share a word: even column in the low half, odd column in the high half.
   assign cell_addr = 11'(cur_row) * WPR + 11'(cur_col[6:1]);

   // While reset is held the port is quiet and the block reports busy.
   assign in_if.in_ready = rdy_c & ~reset;
   assign busy           = busy_c | reset;
   assign fb_en          = en_c & ~reset;
   assign fb_we          = reset ? 4'h0 : we_c;
   assign fb_addr        = reset ? 11'd0 : addr_c;
   assign fb_wdata       = reset ? 32'd0 : wdata_c;

   // Next-state, cursor command and frame-buffer port for each state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      attr_d  = attr_q;
      char_d  = char_q;
      wr_d    = wr_q;
      adv_d   = adv_q;
      cur_op  = CUR_NONE;
      rdy_c   = 1'b0;
      busy_c  = 1'b1;
      en_c    = 1'b0;
      we_c    = 4'h0;
      addr_c  = 11'd0;
      wdata_c = 32'd0;
      case (state_q)
         INIT_CLR: begin
            en_c    = 1'b1;
            we_c    = 4'hF;
            addr_c  = addr_q;
            wdata_c = {DEFAULT_ATTR, CH_SPACE, DEFAULT_ATTR, CH_SPACE};
            addr_d  = addr_q + 11'd1;
            if (addr_q == LAST_WORD) begin
               addr_d  = 11'd0;
               state_d = IDLE;
            end
         end
         IDLE: begin
            rdy_c  = 1'b1;
            busy_c = 1'b0;
            if (in_if.in_valid) begin
               attr_d  = in_if.in_attr;
               char_d  = (in_if.in_data == CH_BS) ? CH_SPACE : in_if.in_data;
               wr_d    = 1'b0;
               adv_d   = 1'b0;
               state_d = CHAR_WR;
               if (is_printable(in_if.in_data)) begin
                  wr_d  = 1'b1;
                  adv_d = 1'b1;
               end else begin
                  case (in_if.in_data)
                     CH_LF: begin
                        cur_op = CUR_LF;
                        if (lf_ovf) begin
                           addr_d  = WPR;
                           state_d = SCR_RD;
                        end
                     end
                     CH_CR: cur_op = CUR_CR;
                     CH_BS: begin
                        // Cursor steps back now, so CHAR_WR blanks the cell under the new cursor.
                        cur_op = CUR_BS;
                        wr_d   = (cur_col != 7'd0);
                     end
                     CH_FF: begin
                        cur_op  = CUR_HOME;
                        addr_d  = 11'd0;
                        state_d = FF_CLR;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CHAR_WR: begin
            if (wr_q) begin
               en_c    = 1'b1;
               we_c    = cur_col[0] ? 4'b1100 : 4'b0011;
               addr_c  = cell_addr;
               wdata_c = {attr_q, char_q, attr_q, char_q};
            end
            state_d = IDLE;
            if (adv_q) begin
               cur_op = CUR_ADV;
               if (adv_ovf) begin
                  addr_d  = WPR;
                  state_d = SCR_RD;
               end
            end
         end
         SCR_RD: begin
            en_c    = 1'b1;
            addr_c  = addr_q;
            state_d = SCR_WR;
         end
         SCR_WR: begin
            en_c    = 1'b1;
            we_c    = 4'hF;
            addr_c  = addr_q - WPR;
            wdata_c = fb_rdata;
            if (addr_q == LAST_WORD) begin
               addr_d  = LAST_ROW_W;
               state_d = ROW_CLR;
            end else begin
               addr_d  = addr_q + 11'd1;
               state_d = SCR_RD;
            end
         end
         ROW_CLR, FF_CLR: begin
            en_c    = 1'b1;
            we_c    = 4'hF;
            addr_c  = addr_q;
            wdata_c = {attr_q, CH_SPACE, attr_q, CH_SPACE};
            addr_d  = addr_q + 11'd1;
            if (addr_q == LAST_WORD) begin
               addr_d  = 11'd0;
               state_d = IDLE;
            end
         end
         default: state_d = INIT_CLR;
      endcase
   end

   // State, word counter and latched byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT_CLR;
         addr_q  <= 11'd0;
         attr_q  <= 8'd0;
         char_q  <= 8'd0;
         wr_q    <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         attr_q  <= attr_d;
         char_q  <= char_d;
         wr_q    <= wr_d;
         adv_q   <= adv_d;
      end
   end

endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: directed byte sequences against a behavioural frame-buffer RAM.
// Latency: checks cycle counts from handshake to in_ready.
// Backpressure: source holds each byte until in_ready.
module tb_vga_text_console;

   typedef struct packed {
      logic [10:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        fb_en;
   logic [3:0]  fb_we;
   logic [10:0] fb_addr;
   logic [31:0] fb_wdata;
   logic [31:0] fb_rdata;
   logic [4:0]  cur_row;
   logic [6:0]  cur_col;
   logic        busy;
   logic        preload;

   logic [31:0] mem [2048];
   wr_t         wlog [$];
   int          rd_cnt   = 0;
   int          busy_cnt = 0;
   int          n_cmp    = 0;
   int          n_bad    = 0;

   vga_text_console_if in_if ();

   vga_text_console dut (
      .clk      (clk),
      .reset    (reset),
      .in_if    (in_if),
      .fb_en    (fb_en),
      .fb_we    (fb_we),
      .fb_addr  (fb_addr),
      .fb_wdata (fb_wdata),
      .fb_rdata (fb_rdata),
      .cur_row  (cur_row),
      .cur_col  (cur_col),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 + 32'(i * 3);
   endfunction

   // Synchronous RAM with byte enables; read data appears the cycle after the read.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
      end else if (fb_en) begin
         if (fb_we == 4'h0) fb_rdata <= mem[fb_addr];
         else for (int k = 0; k < 4; k++)
            if (fb_we[k]) mem[fb_addr][8*k +: 8] <= fb_wdata[8*k +: 8];
      end
   end

   // Port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (fb_en) begin
         if (fb_we == 4'h0) rd_cnt++;
         else wlog.push_back({fb_addr, fb_we, fb_wdata});
      end
      if (busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic wr_t get_wr(input int idx);
      if (idx < wlog.size()) return wlog[idx];
      return '0;
   endfunction

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      int guard = 0;
      @(posedge clk); #1;
      in_if.in_valid = 1'b1;
      in_if.in_data  = d;
      in_if.in_attr  = a;
      while (!in_if.in_ready && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 5000) chk("send_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      in_if.in_valid = 1'b0;
   endtask

   // Negedges from the handshake until in_ready is seen again (inclusive).
   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_if.in_ready && n < 5000);
      #1;
   endtask

   task automatic do_byte(input logic [7:0] d, input logic [7:0] a,
                          output int n, output int bz, output int rd);
      int bb, rb;
      send(d, a);
      bb = busy_cnt;
      rb = rd_cnt;
      wait_idle(n);
      bz = busy_cnt - bb;
      rd = rd_cnt - rb;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, bz, rd, b, bad, g;
      logic [31:0] e;
      reset          = 1'b1;
      preload        = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_data  = 8'h00;
      in_if.in_attr  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {fb_en, fb_we, in_if.in_ready, busy}, {1'b0, 4'h0, 1'b0, 1'b1});
      chk("rst_bus", {fb_addr, fb_wdata}, 64'd0);

      // Power-up clear.
      @(posedge clk); #1 reset = 1'b0;
      b = wlog.size();
      wait_idle(n);
      chk("init_ready_cyc", n, 1201);
      chk("init_wr_cnt", wlog.size() - b, 1200);
      bad = 0;
      for (int i = 0; i < 1200; i++)
         if (get_wr(b + i) !== {11'(i), 4'hF, 32'h0720_0720}) bad++;
      chk("init_wr_seq", bad, 0);
      chk("init_cur", {cur_row, cur_col}, 64'd0);

      // 'A' then 'B' share word 0.
      b = wlog.size();
      do_byte(8'h41, 8'h1E, n, bz, rd);
      chk("A_cyc", n, 2);
      chk("A_wr", get_wr(b), {11'd0, 4'b0011, 32'h1E41_1E41});
      do_byte(8'h42, 8'h1E, n, bz, rd);
      chk("B_wr", get_wr(b + 1), {11'd0, 4'b1100, 32'h1E42_1E42});
      chk("AB_wr_cnt", wlog.size() - b, 2);
      chk("AB_cur", {cur_row, cur_col}, {5'd0, 7'd2});

      // CR: no write, back to column 0.
      b = wlog.size();
      do_byte(8'h0D, 8'h07, n, bz, rd);
      chk("CR_cyc", n, 2);
      chk("CR_wr_cnt", wlog.size() - b, 0);
      chk("CR_cur", {cur_row, cur_col}, 64'd0);

      // Full row 0 wraps to row 1 without scrolling.
      b = wlog.size();
      for (int i = 0; i < 80; i++) do_byte(8'(8'h41 + i % 26), 8'h07, n, bz, rd);
      chk("row_last_cyc", n, 2);
      chk("row_wr_cnt", wlog.size() - b, 80);
      chk("row_last_wr", get_wr(b + 79), {11'd39, 4'b1100, 32'h0742_0742});
      chk("row_cur", {cur_row, cur_col}, {5'd1, 7'd0});

      // Two LFs to (3,0), then BS at column 0 does nothing.
      do_byte(8'h0A, 8'h07, n, bz, rd);
      chk("LF_cyc", n, 2);
      do_byte(8'h0A, 8'h07, n, bz, rd);
      b = wlog.size();
      do_byte(8'h08, 8'h07, n, bz, rd);
      chk("BS0_cyc", n, 2);
      chk("BS0_wr_cnt", wlog.size() - b, 0);
      chk("BS0_cur", {cur_row, cur_col}, {5'd3, 7'd0});

      // BS at (3,4): column 3 is odd, so the blank lands in the high half of word 121.
      for (int i = 0; i < 4; i++) do_byte(8'h78, 8'h07, n, bz, rd);
      b = wlog.size();
      do_byte(8'h08, 8'h07, n, bz, rd);
      chk("BS_wr_cnt", wlog.size() - b, 1);
      chk("BS_wr", get_wr(b), {11'd121, 4'b1100, 32'h0720_0720});
      chk("BS_cur", {cur_row, cur_col}, {5'd3, 7'd3});

      // Move to (29,5) and scroll with LF.
      for (int i = 0; i < 26; i++) do_byte(8'h0A, 8'h07, n, bz, rd);
      for (int i = 0; i < 5; i++) do_byte(8'h79, 8'h07, n, bz, rd);
      chk("pre_scr_cur", {cur_row, cur_col}, {5'd29, 7'd5});
      @(posedge clk); #1 preload = 1'b1;
      @(posedge clk); #1 preload = 1'b0;
      b = wlog.size();
      do_byte(8'h0A, 8'h2F, n, bz, rd);
      chk("scr_cyc", n, 2361);
      chk("scr_busy", bz, 2360);
      chk("scr_rd_cnt", rd, 1160);
      chk("scr_wr_cnt", wlog.size() - b, 1200);
      chk("scr_first_wr", get_wr(b), {11'd0, 4'hF, pat(40)});
      chk("scr_clr_first", get_wr(b + 1160), {11'd1160, 4'hF, 32'h2F20_2F20});
      bad = 0;
      for (int i = 0; i < 1200; i++) begin
         e = (i < 1160) ? pat(i + 40) : 32'h2F20_2F20;
         if (mem[i] !== e) bad++;
      end
      chk("scr_mem", bad, 0);
      chk("scr_cur", {cur_row, cur_col}, {5'd29, 7'd0});

      // Wrap off the last cell triggers a scroll after the char write.
      for (int i = 0; i < 79; i++) do_byte(8'h61, 8'h07, n, bz, rd);
      do_byte(8'h5A, 8'h4E, n, bz, rd);
      chk("wrap_scr_cyc", n, 2362);
      chk("wrap_scr_moved", mem[1159], 32'h4E5A_0761);
      chk("wrap_scr_clr", mem[1199], 32'h4E20_4E20);
      chk("wrap_scr_cur", {cur_row, cur_col}, {5'd29, 7'd0});

      // Other control codes are swallowed.
      b = wlog.size();
      do_byte(8'h01, 8'h07, n, bz, rd);
      chk("disc_cyc", n, 2);
      chk("disc_wr_cnt", wlog.size() - b, 0);
      chk("disc_cur", {cur_row, cur_col}, {5'd29, 7'd0});

      // Form feed clears with its attribute and homes the cursor.
      b = wlog.size();
      do_byte(8'h0C, 8'h70, n, bz, rd);
      chk("FF_cyc", n, 1201);
      chk("FF_wr_cnt", wlog.size() - b, 1200);
      bad = 0;
      for (int i = 0; i < 1200; i++)
         if (get_wr(b + i) !== {11'(i), 4'hF, 32'h7020_7020}) bad++;
      chk("FF_wr_seq", bad, 0);
      chk("FF_cur", {cur_row, cur_col}, 64'd0);

      // Reset in the middle of a form-feed clear restarts the power-up clear.
      do_byte(8'h41, 8'h07, n, bz, rd);
      send(8'h0C, 8'h70);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!(fb_en && fb_addr == 11'd500) && g < 3000);
      if (g >= 3000) chk("FF2_reach500", 64'd0, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_outs", {fb_en, fb_we, in_if.in_ready, busy}, {1'b0, 4'h0, 1'b0, 1'b1});
      chk("rst2_cur", {cur_row, cur_col}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      b = wlog.size();
      wait_idle(n);
      chk("rst2_ready_cyc", n, 1201);
      chk("rst2_first_wr", get_wr(b), {11'd0, 4'hF, 32'h0720_0720});
      chk("rst2_wr_cnt", wlog.size() - b, 1200);
      chk("rst2_cur_end", {cur_row, cur_col}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
